// File: rtl/gray_scale_pipe.sv
// Three-stage RGB-to-gray converter: expand channels, reduce by mode, scale/pack.
// Latency 3 clk, 1 pixel/clk; valid/ready with full backpressure.
module gray_scale_pipe #(
    parameter int R_W   = 3,
    parameter int G_W   = 3,
    parameter int B_W   = 2,
    parameter int OUT_W = 8,
    parameter int PACK  = 1,
    localparam int IN_W = R_W + G_W + B_W,
    localparam int OW   = (PACK != 0) ? IN_W : OUT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] pixel_in,
    input  logic [1:0]      mode,
    input  logic            in_sof,
    input  logic            in_eol,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   pixel_out,
    output logic            out_sof,
    output logic            out_eol
);

    logic [R_W-1:0] w_r;
    logic [G_W-1:0] w_g;
    logic [B_W-1:0] w_b;
    logic [7:0]     w_r8;
    logic [7:0]     w_g8;
    logic [7:0]     w_b8;

    logic           w_ld1;
    logic           w_ld2;
    logic           w_ld3;

    logic [9:0]     w_sum;
    logic [16:0]    w_avg_prod;
    logic [15:0]    w_luma_prod;
    logic [7:0]     w_avg;
    logic [7:0]     w_luma;
    logic [7:0]     w_max_rg;
    logic [7:0]     w_max;
    logic [7:0]     w_gray;
    logic [OW-1:0]  w_pix;

    logic           r1_v;
    logic [7:0]     r1_r8;
    logic [7:0]     r1_g8;
    logic [7:0]     r1_b8;
    logic [1:0]     r1_mode;
    logic           r1_sof;
    logic           r1_eol;

    logic           r2_v;
    logic [7:0]     r2_gray;
    logic           r2_sof;
    logic           r2_eol;

    logic           r3_v;
    logic [OW-1:0]  r3_pix;
    logic           r3_sof;
    logic           r3_eol;

    assign w_r = pixel_in[IN_W-1 -: R_W];
    assign w_g = pixel_in[B_W +: G_W];
    assign w_b = pixel_in[B_W-1:0];

    // Bit replication keeps full-scale inputs at full scale (e.g. 3'b111 -> 8'hFF).
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_expand
        assign w_r8[7-gi] = w_r[R_W-1-(gi % R_W)];
        assign w_g8[7-gi] = w_g[G_W-1-(gi % G_W)];
        assign w_b8[7-gi] = w_b[B_W-1-(gi % B_W)];
    end

    // A stage may load when empty or when the stage after it is also moving.
    assign w_ld3    = !r3_v || out_ready;
    assign w_ld2    = !r2_v || w_ld3;
    assign w_ld1    = !r1_v || w_ld2;
    assign in_ready = w_ld1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_v    <= 1'b0;
            r1_r8   <= '0;
            r1_g8   <= '0;
            r1_b8   <= '0;
            r1_mode <= '0;
            r1_sof  <= 1'b0;
            r1_eol  <= 1'b0;
        end else if (w_ld1) begin
            r1_v <= in_valid;
            if (in_valid) begin
                r1_r8   <= w_r8;
                r1_g8   <= w_g8;
                r1_b8   <= w_b8;
                r1_mode <= mode;
                r1_sof  <= in_sof;
                r1_eol  <= in_eol;
            end
        end
    end

    // 171/512 approximates 1/3 with rounding; 765*171+256 still fits 17 bits.
    assign w_sum       = {2'b00, r1_r8} + {2'b00, r1_g8} + {2'b00, r1_b8};
    assign w_avg_prod  = 17'(w_sum) * 17'd171 + 17'd256;
    assign w_avg       = 8'(w_avg_prod >> 9);
    assign w_luma_prod = 16'(r1_r8) * 16'd77 + 16'(r1_g8) * 16'd150
                       + 16'(r1_b8) * 16'd29 + 16'd128;
    assign w_luma      = 8'(w_luma_prod >> 8);
    assign w_max_rg    = (r1_r8 > r1_g8) ? r1_r8 : r1_g8;
    assign w_max       = (w_max_rg > r1_b8) ? w_max_rg : r1_b8;

    always_comb begin
        w_gray = w_avg;
        case (r1_mode)
            2'd0:    w_gray = w_avg;
            2'd1:    w_gray = w_luma;
            2'd2:    w_gray = r1_g8;
            default: w_gray = w_max;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_v    <= 1'b0;
            r2_gray <= '0;
            r2_sof  <= 1'b0;
            r2_eol  <= 1'b0;
        end else if (w_ld2) begin
            r2_v <= r1_v;
            if (r1_v) begin
                r2_gray <= w_gray;
                r2_sof  <= r1_sof;
                r2_eol  <= r1_eol;
            end
        end
    end

    if (PACK != 0) begin : g_pack
        assign w_pix = {R_W'(r2_gray >> (8 - R_W)),
                        G_W'(r2_gray >> (8 - G_W)),
                        B_W'(r2_gray >> (8 - B_W))};
    end else begin : g_raw
        assign w_pix = OUT_W'(r2_gray >> (8 - OUT_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r3_v   <= 1'b0;
            r3_pix <= '0;
            r3_sof <= 1'b0;
            r3_eol <= 1'b0;
        end else if (w_ld3) begin
            r3_v <= r2_v;
            if (r2_v) begin
                r3_pix <= w_pix;
                r3_sof <= r2_sof;
                r3_eol <= r2_eol;
            end
        end
    end

    assign out_valid = r3_v;
    assign pixel_out = r3_pix;
    assign out_sof   = r3_sof;
    assign out_eol   = r3_eol;

endmodule
